dht_lcd_formatter: RTL and testbench

//  Consumes the BCD humidity/temperature digits produced by the DHT11 reader and

---
 rtl/dht_lcd_formatter.sv | 190 +++++++++++++++++++
 tb/tb_dht_lcd_formatter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_lcd_formatter.sv
`timescale 1ns/1ps
// dht_lcd_formatter
// Converts the four BCD digits from the DHT11 reader into HD44780 command and
// character bytes for the I2C LCD writer. After reset it waits for the panel
// to power up, runs the 4-bit init list once, and then paints a two-line frame:
//   line 1: "HUM: hh%"     line 2: "TMP: tt<deg>C"
// A new frame is painted when the digits differ from the last painted ones, or
// when the display has been idle for REFRESH_US microseconds.
//
// Ports
//   clk1Mhz        in   1 MHz clock, one timer tick per cycle
//   reset          in   synchronous active-low reset
//   humidity10/0   in   BCD humidity tens/units
//   temperature10/0 in  BCD temperature tens/units
//   lcd_byte       out  byte offered to the LCD writer
//   lcd_rs         out  0 = command, 1 = character data
//   lcd_valid      out  byte offered; held with stable data until accepted
//   lcd_ready      in   writer accepts when lcd_valid & lcd_ready at posedge
//   busy           out  high whenever the formatter is not idle
//   frame_done     out  one-cycle pulse when a frame has been fully sent
//
// All gap parameters must be at least 1.
module dht_lcd_formatter #(
    parameter int POWERUP_US = 50_000,
    parameter int CMD_GAP_US = 50,
    parameter int CLEAR_US   = 2_000,
    parameter int REFRESH_US = 500_000
) (
    input  logic       clk1Mhz,
    input  logic       reset,
    input  logic [3:0] humidity10,
    input  logic [3:0] humidity0,
    input  logic [3:0] temperature10,
    input  logic [3:0] temperature0,
    output logic [7:0] lcd_byte,
    output logic       lcd_rs,
    output logic       lcd_valid,
    input  logic       lcd_ready,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_GAP, S_FRAME, S_IDLE} state_t;

    // Timer compares use "last count" values: a wait of N cycles ends on the
    // edge where the timer, cleared on entry, reads N-1.
    localparam logic [18:0] PWR_LAST   = 19'(POWERUP_US - 1);
    localparam logic [18:0] GAP_LAST   = 19'(CMD_GAP_US - 1);
    localparam logic [18:0] CLR_LAST   = 19'(CLEAR_US - 1);
    localparam logic [18:0] REF_LAST   = 19'(REFRESH_US - 1);
    localparam logic [18:0] TMR_MAX    = '1;
    localparam logic [4:0]  INIT_LAST  = 5'd5;
    localparam logic [4:0]  FRAME_LAST = 5'd18;

    state_t      r_state, w_state_nxt;
    logic [18:0] r_timer, w_timer_nxt;
    logic [4:0]  r_idx, w_idx_nxt;
    logic        r_in_frame, w_in_frame_nxt;
    logic [15:0] r_snap, w_snap_nxt;
    logic        r_frame_done, w_frame_done_nxt;
    logic [15:0] w_digits;
    logic [18:0] w_gap_last;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] init_byte(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'h33;
            5'd1:    return 8'h32;
            5'd2:    return 8'h28;
            5'd3:    return 8'h0C;
            5'd4:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Returns {rs, byte} for frame position idx; digits come from the snapshot.
    function automatic logic [8:0] frame_byte(input logic [4:0] idx, input logic [15:0] snap);
        case (idx)
            5'd0:    return {1'b0, 8'h80};
            5'd1:    return {1'b1, 8'h48};
            5'd2:    return {1'b1, 8'h55};
            5'd3:    return {1'b1, 8'h4D};
            5'd4:    return {1'b1, 8'h3A};
            5'd5:    return {1'b1, 8'h20};
            5'd6:    return {1'b1, digit_char(snap[15:12])};
            5'd7:    return {1'b1, digit_char(snap[11:8])};
            5'd8:    return {1'b1, 8'h25};
            5'd9:    return {1'b0, 8'hC0};
            5'd10:   return {1'b1, 8'h54};
            5'd11:   return {1'b1, 8'h4D};
            5'd12:   return {1'b1, 8'h50};
            5'd13:   return {1'b1, 8'h3A};
            5'd14:   return {1'b1, 8'h20};
            5'd15:   return {1'b1, digit_char(snap[7:4])};
            5'd16:   return {1'b1, digit_char(snap[3:0])};
            5'd17:   return {1'b1, 8'hDF};
            default: return {1'b1, 8'h43};
        endcase
    endfunction

    assign w_digits   = {humidity10, humidity0, temperature10, temperature0};
    // The clear-display command is the last init byte and needs the long gap.
    assign w_gap_last = (!r_in_frame && r_idx == INIT_LAST) ? CLR_LAST : GAP_LAST;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk1Mhz) begin
        if (!reset) begin
            r_state      <= S_PWRUP;
            r_timer      <= '0;
            r_idx        <= '0;
            r_in_frame   <= 1'b0;
            r_snap       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_idx        <= w_idx_nxt;
            r_in_frame   <= w_in_frame_nxt;
            r_snap       <= w_snap_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = (r_timer == TMR_MAX) ? r_timer : r_timer + 19'd1;
        w_idx_nxt        = r_idx;
        w_in_frame_nxt   = r_in_frame;
        w_snap_nxt       = r_snap;
        w_frame_done_nxt = 1'b0;
        lcd_valid        = 1'b0;
        lcd_byte         = 8'h00;
        lcd_rs           = 1'b0;
        busy             = (r_state != S_IDLE);

        case (r_state)
            S_PWRUP: begin
                if (r_timer == PWR_LAST) begin
                    w_state_nxt    = S_INIT;
                    w_idx_nxt      = '0;
                    w_in_frame_nxt = 1'b0;
                end
            end
            S_INIT: begin
                lcd_valid = 1'b1;
                lcd_byte  = init_byte(r_idx);
                if (lcd_ready) w_state_nxt = S_GAP;
            end
            S_FRAME: begin
                lcd_valid          = 1'b1;
                {lcd_rs, lcd_byte} = frame_byte(r_idx, r_snap);
                if (lcd_ready) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_timer == w_gap_last) begin
                    if (!r_in_frame && r_idx == INIT_LAST) begin
                        w_state_nxt    = S_FRAME;
                        w_idx_nxt      = '0;
                        w_in_frame_nxt = 1'b1;
                        w_snap_nxt     = w_digits;
                    end else if (!r_in_frame) begin
                        w_state_nxt = S_INIT;
                        w_idx_nxt   = r_idx + 5'd1;
                    end else if (r_idx == FRAME_LAST) begin
                        w_state_nxt      = S_IDLE;
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FRAME;
                        w_idx_nxt   = r_idx + 5'd1;
                    end
                end
            end
            S_IDLE: begin
                // Refresh and digit change arriving together still start one frame.
                if (r_timer == REF_LAST || w_digits != r_snap) begin
                    w_state_nxt = S_FRAME;
                    w_idx_nxt   = '0;
                    w_snap_nxt  = w_digits;
                end
            end
            default: w_state_nxt = S_PWRUP;
        endcase

        if (w_state_nxt != r_state) w_timer_nxt = '0;
    end

endmodule

// File: tb/tb_dht_lcd_formatter.sv
`timescale 1ns/1ps
module tb_dht_lcd_formatter;

    localparam int PWR = 200;
    localparam int GAP = 5;
    localparam int CLR = 40;
    localparam int REF = 1000;

    logic       clk1Mhz = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] humidity10 = 4'd0;
    logic [3:0] humidity0 = 4'd0;
    logic [3:0] temperature10 = 4'd0;
    logic [3:0] temperature0 = 4'd0;
    logic       lcd_ready = 1'b0;
    logic [7:0] lcd_byte;
    logic       lcd_rs;
    logic       lcd_valid;
    logic       busy;
    logic       frame_done;

    dht_lcd_formatter #(
        .POWERUP_US(PWR), .CMD_GAP_US(GAP), .CLEAR_US(CLR), .REFRESH_US(REF)
    ) dut (
        .clk1Mhz(clk1Mhz), .reset(reset),
        .humidity10(humidity10), .humidity0(humidity0),
        .temperature10(temperature10), .temperature0(temperature0),
        .lcd_byte(lcd_byte), .lcd_rs(lcd_rs), .lcd_valid(lcd_valid),
        .lcd_ready(lcd_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk1Mhz = ~clk1Mhz;

    typedef struct { logic [7:0] b; logic rs; int cyc; } tx_t;
    tx_t        tx_q[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         stab_err = 0;
    logic       p_hold = 1'b0;
    logic [7:0] p_byte = 8'h00;
    logic       p_rs = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          rd = 0;
    int          done_base = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] cur_d = 16'h0000;
    logic [7:0]  init_l [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

    always @(posedge clk1Mhz) cyc <= cyc + 1;

    // Transfer log and handshake-stability watcher, sampled mid-cycle.
    always @(negedge clk1Mhz) begin
        if (reset && lcd_valid && lcd_ready)
            tx_q.push_back('{b: lcd_byte, rs: lcd_rs, cyc: cyc});
        if (frame_done) done_cnt <= done_cnt + 1;
        if (p_hold && (!lcd_valid || lcd_byte !== p_byte || lcd_rs !== p_rs))
            stab_err <= stab_err + 1;
        p_hold <= reset && lcd_valid && !lcd_ready;
        p_byte <= lcd_byte;
        p_rs   <= lcd_rs;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t (required: finished)", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] enc(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        return 8'h3F;
    endfunction

    function automatic logic [8:0] got_at(input int k);
        if (k < tx_q.size()) return {tx_q[k].rs, tx_q[k].b};
        return 9'bx;
    endfunction

    // Reference frame: the two text lines with cursor-address commands.
    task automatic build_frame(input logic [15:0] d);
        string s1 = "HUM: ";
        string s2 = "TMP: ";
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < s1.len(); i++) exp_q.push_back({1'b1, s1[i]});
        exp_q.push_back({1'b1, enc(d[15:12])});
        exp_q.push_back({1'b1, enc(d[11:8])});
        exp_q.push_back({1'b1, 8'h25});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < s2.len(); i++) exp_q.push_back({1'b1, s2[i]});
        exp_q.push_back({1'b1, enc(d[7:4])});
        exp_q.push_back({1'b1, enc(d[3:0])});
        exp_q.push_back({1'b1, 8'hDF});
        exp_q.push_back({1'b1, 8'h43});
    endtask

    task automatic set_digits(input logic [15:0] d);
        {humidity10, humidity0, temperature10, temperature0} = d;
        cur_d = d;
    endtask

    task automatic rand_digits(input bit wide, output logic [15:0] d);
        int hi;
        hi = wide ? 15 : 9;
        do begin
            d = {4'($urandom_range(0, hi)), 4'($urandom_range(0, hi)),
                 4'($urandom_range(0, hi)), 4'($urandom_range(0, hi))};
        end while (d == cur_d);
    endtask

    task automatic wait_q(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (tx_q.size() >= n) begin ok = 1'b1; break; end
            @(posedge clk1Mhz); #1;
        end
    endtask

    task automatic wait_valid(input int bound, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk1Mhz); #1;
            n++;
            if (lcd_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk1Mhz); #1;
            if (frame_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        lcd_ready = 1'b1;
        repeat (3) @(posedge clk1Mhz);
        #1;
        total++; if (lcd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", lcd_valid); end
        total++; if (lcd_byte !== 8'h00) begin bad++; $display("FAIL rst_byte got=%h exp=00", lcd_byte); end
        total++; if (lcd_rs !== 1'b0) begin bad++; $display("FAIL rst_rs got=%b exp=0", lcd_rs); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    endtask

    task automatic test_init;
        int base, n, dt, need;
        bit ok;
        set_digits(16'h4523);
        base = tx_q.size();
        done_base = done_cnt;
        reset = 1'b1;
        wait_valid(PWR + 20, n, ok);
        total++; if (!ok || n != PWR) begin bad++; $display("FAIL init_first_valid got=%0d cycles exp=%0d", n, PWR); end
        wait_q(base + 7, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL init_bytes_timeout got=%0d bytes exp=%0d", tx_q.size() - base, 7); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got_at(base + i) !== {1'b0, init_l[i]}) begin
                bad++; $display("FAIL init_byte%0d got=%h exp=%h", i, got_at(base + i), {1'b0, init_l[i]});
            end
        end
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                dt = tx_q[base + i + 1].cyc - tx_q[base + i].cyc;
                need = (i == 5) ? CLR : GAP;
                total++;
                if (dt < need) begin bad++; $display("FAIL init_spacing%0d got=%0d exp>=%0d", i, dt, need); end
            end
        end
        rd = base + 6;
    endtask

    task automatic test_frame;
        bit ok;
        wait_done(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL frame1_done got=timeout exp=pulse"); end
        build_frame(16'h4523);
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(rd + i) !== exp_q[i]) begin bad++; $display("FAIL frame1_byte%0d got=%h exp=%h", i, got_at(rd + i), exp_q[i]); end
        end
        total++; if (tx_q.size() != rd + 19) begin bad++; $display("FAIL frame1_count got=%0d exp=%0d", tx_q.size() - rd, 19); end
        repeat (3) @(posedge clk1Mhz);
        #1;
        total++; if (done_cnt - done_base != 1) begin bad++; $display("FAIL frame1_done_count got=%0d exp=1", done_cnt - done_base); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL frame1_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stall;
        logic [15:0] d;
        logic [8:0]  held;
        int base, n, moved;
        bit ok;
        rand_digits(1'b0, d);
        base = tx_q.size();
        set_digits(d);
        build_frame(d);
        wait_q(base + 5, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_pre_timeout got=%0d exp=5", tx_q.size() - base); end
        wait_valid(200, n, ok);
        lcd_ready = 1'b0;
        held = {lcd_rs, lcd_byte};
        moved = 0;
        repeat (300) begin
            @(posedge clk1Mhz); #1;
            if (!lcd_valid || {lcd_rs, lcd_byte} !== held || !busy) moved++;
        end
        total++; if (moved != 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", moved); end
        total++; if (held !== exp_q[5]) begin bad++; $display("FAIL stall_byte got=%h exp=%h", held, exp_q[5]); end
        lcd_ready = 1'b1;
        wait_done(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_done got=timeout exp=pulse"); end
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]); end
        end
        total++; if (tx_q.size() != base + 19) begin bad++; $display("FAIL stall_count got=%0d exp=19", tx_q.size() - base); end
    endtask

    task automatic test_change_midframe;
        logic [15:0] d, d2;
        int base;
        bit ok;
        do rand_digits(1'b0, d); while (d[11:8] == 4'd9);
        base = tx_q.size();
        set_digits(d);
        build_frame(d);
        wait_q(base + 4, 500, ok);
        d2 = d;
        d2[11:8] = d[11:8] + 4'd1;
        set_digits(d2);
        wait_done(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL chg_done got=timeout exp=pulse"); end
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL chg_old_byte%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]); end
        end
        total++; if (tx_q.size() != base + 19) begin bad++; $display("FAIL chg_old_count got=%0d exp=19", tx_q.size() - base); end
        base = tx_q.size();
        build_frame(d2);
        @(posedge clk1Mhz); #1;
        total++; if (lcd_valid !== 1'b1 || lcd_byte !== 8'h80) begin
            bad++; $display("FAIL chg_restart got=valid %b byte %h exp=valid 1 byte 80", lcd_valid, lcd_byte);
        end
        wait_done(1000, ok);
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL chg_new_byte%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]); end
        end
    endtask

    task automatic test_refresh;
        logic [15:0] d;
        logic [8:0]  g;
        int base, n;
        bit ok;
        d = cur_d;
        d[7:4] = 4'hC;
        base = tx_q.size();
        set_digits(d);
        build_frame(d);
        wait_done(1000, ok);
        g = got_at(base + 15);
        total++; if (g[7:0] !== 8'h3F) begin bad++; $display("FAIL ref_qmark got=%h exp=3F", g[7:0]); end
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL ref_chg_byte%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ref_idle_busy got=%b exp=0", busy); end
        base = tx_q.size();
        wait_valid(REF + 50, n, ok);
        total++; if (!ok || n != REF) begin bad++; $display("FAIL ref_interval got=%0d exp=%0d", n, REF); end
        wait_done(1000, ok);
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL ref_byte%0d got=%h exp=%h", i, got_at(base + i), exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] d;
        int base, n;
        bit ok;
        rand_digits(1'b0, d);
        base = tx_q.size();
        set_digits(d);
        wait_q(base + 3, 500, ok);
        lcd_ready = 1'b0;
        wait_valid(100, n, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_valid got=timeout exp=valid"); end
        reset = 1'b0;
        @(posedge clk1Mhz); #1;
        total++; if (lcd_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_drop got=%b exp=0", lcd_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        total++; if (lcd_byte !== 8'h00) begin bad++; $display("FAIL rmid_byte got=%h exp=00", lcd_byte); end
        reset = 1'b1;
        lcd_ready = 1'b1;
        base = tx_q.size();
        wait_valid(PWR + 20, n, ok);
        total++; if (!ok || n != PWR) begin bad++; $display("FAIL rmid_pwrup got=%0d exp=%0d", n, PWR); end
        wait_q(base + 6, 1000, ok);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (got_at(base + i) !== {1'b0, init_l[i]}) begin
                bad++; $display("FAIL rmid_init%0d got=%h exp=%h", i, got_at(base + i), {1'b0, init_l[i]});
            end
        end
        build_frame(d);
        wait_done(2000, ok);
        for (int i = 0; i < 19; i++) begin
            total++;
            if (got_at(base + 6 + i) !== exp_q[i]) begin bad++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, got_at(base + 6 + i), exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        int base;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            rand_digits(1'b1, d);
            base = tx_q.size();
            set_digits(d);
            build_frame(d);
            ok = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                @(posedge clk1Mhz); #1;
                lcd_ready = ($urandom_range(0, 3) != 0);
                if (frame_done) begin ok = 1'b1; break; end
            end
            total++; if (!ok) begin bad++; $display("FAIL b2b%0d_done got=timeout exp=pulse", it); end
            for (int i = 0; i < 19; i++) begin
                total++;
                if (got_at(base + i) !== exp_q[i]) begin bad++; $display("FAIL b2b%0d_byte%0d got=%h exp=%h", it, i, got_at(base + i), exp_q[i]); end
            end
            total++; if (tx_q.size() != base + 19) begin bad++; $display("FAIL b2b%0d_count got=%0d exp=19", it, tx_q.size() - base); end
        end
        lcd_ready = 1'b1;
        repeat (2) @(posedge clk1Mhz);
        #1;
        total++; if (stab_err != 0) begin bad++; $display("FAIL handshake_stability got=%0d violations exp=0", stab_err); end
    endtask

    initial begin
        test_reset;
        test_init;
        test_frame;
        test_stall;
        test_change_midframe;
        test_refresh;
        test_reset_midframe;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
